core_l1i_cache: RTL



---
 rtl/core_l1i_pkg.sv | 22 ++
 rtl/core_l1i_fsm.sv | 46 ++++
 rtl/core_l1i_cache.sv | 63 ++++++
 3 files changed

// File: rtl/core_l1i_pkg.sv
// core_l1i_pkg: shared state type, field widths and address helpers for the L1 instruction cache
package core_l1i_pkg;
  localparam int IDX_W = 4;
  localparam int LINES = 2 ** IDX_W;
  localparam int WORDS_PER_LINE = 4;
  localparam int TAG_W = 32 - IDX_W - 4;
  typedef enum logic [1:0] {IDLE, REQ, REFILL} state_t;
  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [IDX_W-1:0] idx_t;
  function automatic tag_t tag_of(input logic [31:0] a);
    return a[31:IDX_W+4];
  endfunction
  function automatic idx_t idx_of(input logic [31:0] a);
    return a[IDX_W+3:4];
  endfunction
  function automatic logic [1:0] word_of(input logic [31:0] a);
    return a[3:2];
  endfunction
  function automatic logic [31:0] line_addr(input logic [31:0] a);
    return {a[31:4], 4'b0};
  endfunction
endpackage

// File: rtl/core_l1i_fsm.sv
// core_l1i_fsm: miss FSM, refill beat counter, sticky flush flag and memory request registers
module core_l1i_fsm
  import core_l1i_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic [31:0] addr,
  input  logic        miss,
  input  logic        flush,
  input  logic        mem_req_ack,
  input  logic        mem_resp_val,
  output state_t      state,
  output logic [1:0]  cnt,
  output logic        beat_we,
  output logic        fill_done,
  output logic        fill_valid,
  output logic        mem_req_val,
  output logic [31:0] mem_req_addr
);
  state_t state_nx;
  logic   flushed;
  logic   start;
  always_comb begin
    start       = (state == IDLE) & miss & ~flush;
    beat_we     = (state == REFILL) & mem_resp_val;
    fill_done   = beat_we & (cnt == 2'd3);
    fill_valid  = fill_done & ~flushed & ~flush;
    mem_req_val = state == REQ;
    state_nx    = start ? REQ :
                  (state == REQ && mem_req_ack) ? REFILL :
                  fill_done ? IDLE : state;
  end
  // a flush seen anywhere in REQ/REFILL keeps the in-flight line from being validated
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      flushed      <= 1'b0;
      mem_req_addr <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= (state == REQ) ? 2'd0 : beat_we ? cnt + 2'd1 : cnt;
      flushed <= (state_nx != IDLE) & (flushed | flush);
      if (start) mem_req_addr <= line_addr(addr);
    end
endmodule

// File: rtl/core_l1i_cache.sv
// core_l1i_cache: direct-mapped read-only L1 instruction cache with same-cycle hits and 4-beat refill
module core_l1i_cache
  import core_l1i_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic [31:0] l1i_addr_in,
  input  logic        l1i_val_in,
  input  logic        l1i_flush_in,
  output logic [31:0] l1i_data_out,
  output logic        l1i_ack_out,
  output logic        l1i_stall_out,
  output logic        mem_req_val_out,
  output logic [31:0] mem_req_addr_out,
  input  logic        mem_req_ack_in,
  input  logic        mem_resp_val_in,
  input  logic [31:0] mem_resp_data_in
);
  logic [LINES-1:0] valid_q;
  tag_t             tag_q [LINES];
  logic [31:0]      data_q [LINES][WORDS_PER_LINE];
  state_t           state;
  logic [1:0]       cnt;
  logic             beat_we;
  logic             fill_done;
  logic             fill_valid;
  logic             hit;
  idx_t             idx;
  idx_t             fill_idx;
  always_comb begin
    idx           = idx_of(l1i_addr_in);
    fill_idx      = idx_of(mem_req_addr_out);
    hit           = l1i_val_in & valid_q[idx] & (tag_q[idx] == tag_of(l1i_addr_in)) & (state == IDLE);
    l1i_ack_out   = hit;
    l1i_data_out  = hit ? data_q[idx][word_of(l1i_addr_in)] : '0;
    l1i_stall_out = (l1i_val_in & ~hit) | (state != IDLE);
  end
  core_l1i_fsm u_fsm (
    .clk          (clk),
    .n_rst        (n_rst),
    .addr         (l1i_addr_in),
    .miss         (l1i_val_in & ~hit),
    .flush        (l1i_flush_in),
    .mem_req_ack  (mem_req_ack_in),
    .mem_resp_val (mem_resp_val_in),
    .state        (state),
    .cnt          (cnt),
    .beat_we      (beat_we),
    .fill_done    (fill_done),
    .fill_valid   (fill_valid),
    .mem_req_val  (mem_req_val_out),
    .mem_req_addr (mem_req_addr_out)
  );
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) valid_q <= '0;
    else if (l1i_flush_in) valid_q <= '0;
    else if (fill_valid) valid_q[fill_idx] <= 1'b1;
  // the latched request address names the line being filled, whatever fetch does meanwhile
  always_ff @(posedge clk) begin
    if (beat_we) data_q[fill_idx][cnt] <= mem_resp_data_in;
    if (fill_done) tag_q[fill_idx] <= tag_of(mem_req_addr_out);
  end
endmodule
